fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage RV32I core. Sits directly upstream of
//  the decode/control block and feeds it opcode, funct3 and funct7[5] along with pc_d and rs/rd fields.
//  Owns the PC: sequential +4, redirect on taken branch from EX, hold on load-use stall.
//  Provides halt (ecall stop) and debug single-step.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  IMEM_AW    10             instruction ROM word-address width
// PORTS
//  clk            in   1        core clock, all state updates on posedge
//  rst            in   1        synchronous reset, active-high
//  imem_addr      out  IMEM_AW  word address to async-read IROM, = pc_f[IMEM_AW+1:2]
//  imem_rdata     in   32       instruction at imem_addr, same cycle
//  stall_f        in   1        load-use hazard: hold PC and IF/ID
//  branch_taken   in   1        EX resolved redirect
//  branch_target  in   32       redirect PC, word aligned
//  halt           in   1        stop request (ecall seen by control)
//  step           in   1        debug: advance one instruction while halted
//  pc_f           out  32       current fetch PC
//  pc_d           out  32       PC of instruction in ID
//  instr_d        out  32       instruction in ID
//  opcode_d       out  7        instr_d[6:0]
//  funct3_d       out  3        instr_d[14:12]
//  funct7_d       out  1        instr_d[30] (sub/sra select)
//  rs1_d,rs2_d,rd_d out 5 each  register fields
//  valid_d        out  1        ID slot holds a real instruction
//  halted         out  1        FSM in HALT
// BEHAVIOUR
//  Reset: pc_f=RESET_PC, pc_d=0, instr_d=NOP (32'h0000_0013), valid_d=0, FSM=RUN, halted=0.
//  FSM: RUN -halt-> HALT; HALT -step-> STEP; STEP -> HALT (unconditional, 1 cycle).
//    HALT without step stays; halt deasserted in HALT -> RUN.
//  Fetch enable fe = (state==RUN & ~halt) | state==STEP.
//  Per-cycle priority: rst > branch_taken > stall_f > ~fe > normal.
//   branch_taken: pc_f<=branch_target; IF/ID<=NOP, valid_d<=0 (flush).
//     Overrides stall_f and halt in the same cycle.
//   stall_f: pc_f, pc_d, instr_d, valid_d all hold.
//   ~fe: pc_f holds; IF/ID<=NOP, valid_d<=0 (bubble drains pipe).
//   normal: pc_d<=pc_f; instr_d<=imem_rdata; valid_d<=1; pc_f<=pc_f+4.
//  Latency: instr at pc_f visible on instr_d one cycle later.
//  Arithmetic: pc_f+4 wraps modulo 2^32. imem_addr truncates; PC beyond ROM aliases.
//  STEP with stall_f: step consumed, no fetch.
//  STEP with branch_taken: redirect only, FSM still returns to HALT.
//  Field outputs are pure slices of instr_d; bubble decodes as addi x0,x0,0.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch[31:0] and perf_bubble[31:0].
//    perf_fetch increments on each normal cycle.
//    perf_bubble increments on each flush or ~fe bubble cycle.
//    Both clear on rst and wrap at 2^32.
//  FETCH_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared header core_defs.vh: NOP_INSTR, FSM encodings (RUN=2'd0, HALT=2'd1, STEP=2'd2),
//    opcode field ranges.
//  Sub-module if_id_reg: 64-bit pc/instr + valid register with hold/flush inputs.
//    Reused for later stage registers.
//  PC mux and FSM stay in fetch_stage.
// TESTING
//  1. rst 2 cycles, ROM linear: pc_f 0,4,8,...; instr_d=ROM[0] one cycle after rst drops; valid_d=1.
//  2. stall_f high 2 cycles at pc_f=0x8: pc_f stays 0x8, instr_d/pc_d held.
//     Resumes with pc_d=0x8 next.
//  3. branch_taken=1, target=0x40, stall_f=1 same cycle: next pc_f=0x40, instr_d=0x13, valid_d=0.
//     pc_d=0x40 one cycle later.
//  4. halt pulsed at pc_f=0x10: halted=1, pc_f stays 0x10, valid_d=0.
//     step pulse: pc_d=0x10 valid once, pc_f=0x14, back to HALT.
//  5. rst asserted mid-STEP: pc_f=RESET_PC, FSM=RUN, valid_d=0 next cycle.
//  6. With FETCH_PERF_CNT_EN: 5 normal + 1 flush + 2 halt cycles gives perf_fetch=5, perf_bubble=3.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: bubble encoding, sequencer states and RV32I field positions.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } fetch_state_e;

    localparam int OPC_MSB    = 6;
    localparam int OPC_LSB    = 0;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;
    localparam int F3_MSB     = 14;
    localparam int F3_LSB     = 12;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;
    localparam int F7_ALT_BIT = 30;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pc/instr/valid pipeline register; flush beats hold so a redirect always kills the slot.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    output logic [31:0] q_pc,
    output logic [31:0] q_instr,
    output logic        q_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_pc    <= 32'h0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!hold) begin
            r_pc    <= d_pc;
            r_instr <= d_instr;
            r_valid <= 1'b1;
        end
    end

    assign q_pc    = r_pc;
    assign q_instr = r_instr;
    assign q_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC mux, halt/step sequencer and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the perf_fetch / perf_bubble counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               stall_f,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               halt,
    input  logic               step,
    output logic [31:0]        pc_f,
    output logic [31:0]        pc_d,
    output logic [31:0]        instr_d,
    output logic [6:0]         opcode_d,
    output logic [2:0]         funct3_d,
    output logic               funct7_d,
    output logic [4:0]         rs1_d,
    output logic [4:0]         rs2_d,
    output logic [4:0]         rd_d,
    output logic               valid_d,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_bubble
`endif
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_halted;
    logic         w_fe;
    logic         w_normal;
    logic         w_bubble;

    assign w_fe     = (r_state == ST_RUN && !halt) || (r_state == ST_STEP);
    assign w_normal = !branch_taken && !stall_f && w_fe;
    // Redirect flushes even under stall; otherwise an idle fetch drains the pipe with NOPs.
    assign w_bubble = branch_taken || (!stall_f && !w_fe);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            if (branch_taken)
                r_pc <= branch_target;
            else if (w_normal)
                r_pc <= r_pc + 32'd4;

            case (r_state)
                ST_RUN: begin
                    if (halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (step) begin
                        r_state  <= ST_STEP;
                        r_halted <= 1'b0;
                    end else if (!halt) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                ST_STEP: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    fetch_stage_if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .hold    (stall_f),
        .flush   (w_bubble),
        .d_pc    (r_pc),
        .d_instr (imem_rdata),
        .q_pc    (pc_d),
        .q_instr (instr_d),
        .q_valid (valid_d)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch  <= 32'h0;
            r_perf_bubble <= 32'h0;
        end else begin
            if (w_normal)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_bubble)
                r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end

    assign perf_fetch  = r_perf_fetch;
    assign perf_bubble = r_perf_bubble;
`endif

    assign pc_f      = r_pc;
    assign halted    = r_halted;
    // ROM is word addressed; upper PC bits alias.
    assign imem_addr = r_pc[IMEM_AW+1:2];

    assign opcode_d  = instr_d[OPC_MSB:OPC_LSB];
    assign funct3_d  = instr_d[F3_MSB:F3_LSB];
    assign funct7_d  = instr_d[F7_ALT_BIT];
    assign rs1_d     = instr_d[RS1_MSB:RS1_LSB];
    assign rs2_d     = instr_d[RS2_MSB:RS2_LSB];
    assign rd_d      = instr_d[RD_MSB:RD_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_f = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        halt = 1'b0;
    logic        step = 1'b0;
    logic [31:0] pc_f, pc_d, instr_d;
    logic [6:0]  opcode_d;
    logic [2:0]  funct3_d;
    logic        funct7_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        valid_d, halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_bubble;
    logic [31:0] m_pf, m_pb;
`endif

    logic [31:0] rom [1024];
    assign imem_rdata = rom[imem_addr];

    int errors = 0;
    int checks = 0;

    // behavioural model state: mode 0=running, 1=halted, 2=single step in progress
    logic [31:0] m_pc, m_pcd, m_instr;
    logic        m_valid;
    int          m_mode;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall_f(stall_f), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .step(step), .pc_f(pc_f), .pc_d(pc_d), .instr_d(instr_d),
        .opcode_d(opcode_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .valid_d(valid_d), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch(perf_fetch), .perf_bubble(perf_bubble)
`endif
    );

    // Advance the model by one clock from the current inputs, then clock the DUT and settle.
    task automatic tick();
        bit fetching;
        fetching = (m_mode == 0 && !halt) || (m_mode == 2);
        if (rst) begin
            m_pc = 32'h0; m_pcd = 32'h0; m_instr = 32'h13; m_valid = 1'b0; m_mode = 0;
`ifdef FETCH_PERF_CNT_EN
            m_pf = 0; m_pb = 0;
`endif
        end else begin
            if (branch_taken) begin
                m_pc = branch_target; m_pcd = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
                m_pb = m_pb + 1;
`endif
            end else if (stall_f) begin
                // everything holds
            end else if (!fetching) begin
                m_pcd = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
                m_pb = m_pb + 1;
`endif
            end else begin
                m_pcd = m_pc; m_instr = rom[m_pc[11:2]]; m_valid = 1'b1; m_pc = m_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
                m_pf = m_pf + 1;
`endif
            end
            if (m_mode == 2)      m_mode = 1;
            else if (m_mode == 1) m_mode = step ? 2 : (halt ? 1 : 0);
            else if (halt)        m_mode = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall_f = 0; branch_taken = 0; halt = 0; step = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc_f !== 32'h0)  begin errors++; $display("FAIL reset_pc_f got=%h exp=%h", pc_f, 32'h0); end
        checks++; if (pc_d !== 32'h0)  begin errors++; $display("FAIL reset_pc_d got=%h exp=%h", pc_d, 32'h0); end
        checks++; if (instr_d !== 32'h13) begin errors++; $display("FAIL reset_instr_d got=%h exp=%h", instr_d, 32'h13); end
        checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid_d got=%b exp=0", valid_d); end
        checks++; if (halted !== 1'b0)  begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        tick();
        checks++; if (instr_d !== rom[0] || valid_d !== 1'b1 || pc_d !== 32'h0 || pc_f !== 32'h4)
            begin errors++; $display("FAIL linear_first got=%h/%b/%h/%h exp=%h/1/0/4", instr_d, valid_d, pc_d, pc_f, rom[0]); end
        tick();
        checks++; if (pc_f !== 32'h8 || pc_d !== 32'h4 || instr_d !== rom[1])
            begin errors++; $display("FAIL linear_second got=%h/%h/%h exp=8/4/%h", pc_f, pc_d, instr_d, rom[1]); end
    endtask

    task automatic test_stall();
        stall_f = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc_f !== 32'h8 || pc_d !== 32'h4 || instr_d !== rom[1] || valid_d !== 1'b1)
                begin errors++; $display("FAIL stall_hold got=%h/%h/%h/%b exp=8/4/%h/1", pc_f, pc_d, instr_d, valid_d, rom[1]); end
        end
        stall_f = 1'b0;
        tick();
        checks++; if (pc_d !== 32'h8 || instr_d !== rom[2] || pc_f !== 32'hC)
            begin errors++; $display("FAIL stall_resume got=%h/%h/%h exp=8/%h/c", pc_d, instr_d, pc_f, rom[2]); end
    endtask

    task automatic test_branch_over_stall();
        branch_taken = 1'b1; branch_target = 32'h40; stall_f = 1'b1;
        tick();
        checks++; if (pc_f !== 32'h40 || instr_d !== 32'h13 || valid_d !== 1'b0)
            begin errors++; $display("FAIL branch_flush got=%h/%h/%b exp=40/13/0", pc_f, instr_d, valid_d); end
        checks++; if (opcode_d !== 7'h13 || rd_d !== 5'd0 || rs1_d !== 5'd0 || funct3_d !== 3'd0)
            begin errors++; $display("FAIL bubble_fields got=%h/%h/%h/%h exp=13/0/0/0", opcode_d, rd_d, rs1_d, funct3_d); end
        branch_taken = 1'b0; stall_f = 1'b0;
        tick();
        checks++; if (pc_d !== 32'h40 || valid_d !== 1'b1 || instr_d !== rom[16])
            begin errors++; $display("FAIL branch_target_fetch got=%h/%b/%h exp=40/1/%h", pc_d, valid_d, instr_d, rom[16]); end
    endtask

    task automatic test_halt_step();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pc_f !== 32'h10) begin errors++; $display("FAIL halt_setup got=%h exp=10", pc_f); end
        halt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (halted !== 1'b1 || pc_f !== 32'h10 || valid_d !== 1'b0)
                begin errors++; $display("FAIL halt_hold got=%b/%h/%b exp=1/10/0", halted, pc_f, valid_d); end
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (pc_f !== 32'h10 || valid_d !== 1'b0)
            begin errors++; $display("FAIL step_enter got=%h/%b exp=10/0", pc_f, valid_d); end
        tick();
        checks++; if (pc_d !== 32'h10 || valid_d !== 1'b1 || pc_f !== 32'h14 || instr_d !== rom[4] || halted !== 1'b1)
            begin errors++; $display("FAIL step_fetch got=%h/%b/%h/%h/%b exp=10/1/14/%h/1", pc_d, valid_d, pc_f, instr_d, halted, rom[4]); end
        tick();
        checks++; if (valid_d !== 1'b0 || pc_f !== 32'h14 || halted !== 1'b1)
            begin errors++; $display("FAIL step_rehalt got=%b/%h/%b exp=0/14/1", valid_d, pc_f, halted); end
    endtask

    task automatic test_reset_mid_step();
        step = 1'b1;
        tick();
        step = 1'b0; rst = 1'b1;
        tick();
        checks++; if (pc_f !== 32'h0 || valid_d !== 1'b0 || halted !== 1'b0)
            begin errors++; $display("FAIL rst_mid_step got=%h/%b/%b exp=0/0/0", pc_f, valid_d, halted); end
        rst = 1'b0; halt = 1'b0;
        tick();
        checks++; if (pc_f !== 32'h4 || valid_d !== 1'b1 || instr_d !== rom[0])
            begin errors++; $display("FAIL rst_then_run got=%h/%b/%h exp=4/1/%h", pc_f, valid_d, instr_d, rom[0]); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_imem_addr got=%h exp=3ff", imem_addr); end
        tick();
        checks++; if (pc_f !== 32'h0 || pc_d !== 32'hFFFF_FFFC || instr_d !== rom[1023])
            begin errors++; $display("FAIL wrap_pc got=%h/%h/%h exp=0/fffffffc/%h", pc_f, pc_d, instr_d, rom[1023]); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        branch_taken = 1'b0; halt = 1'b1;
        tick(); tick();
        halt = 1'b0;
        checks++; if (perf_fetch !== 32'd5)  begin errors++; $display("FAIL perf_fetch got=%0d exp=5", perf_fetch); end
        checks++; if (perf_bubble !== 32'd3) begin errors++; $display("FAIL perf_bubble got=%0d exp=3", perf_bubble); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] e_instr;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 59) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                        : ($urandom & 32'hFFFF_FFFC);
            stall_f      = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 5) == 0) halt = ~halt;
            step         = ($urandom_range(0, 2) == 0);
            tick();
            e_instr = m_instr;
            checks++; if (pc_f !== m_pc) begin errors++; $display("FAIL rnd_pc_f cyc=%0d got=%h exp=%h", n, pc_f, m_pc); end
            checks++; if (pc_d !== m_pcd || instr_d !== m_instr || valid_d !== m_valid)
                begin errors++; $display("FAIL rnd_if_id cyc=%0d got=%h/%h/%b exp=%h/%h/%b", n, pc_d, instr_d, valid_d, m_pcd, m_instr, m_valid); end
            checks++; if (halted !== (m_mode == 1)) begin errors++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", n, halted, m_mode == 1); end
            checks++; if (imem_addr !== m_pc[11:2]) begin errors++; $display("FAIL rnd_imem_addr cyc=%0d got=%h exp=%h", n, imem_addr, m_pc[11:2]); end
            checks++; if ({opcode_d, funct3_d, funct7_d, rs1_d, rs2_d, rd_d} !==
                          {e_instr[6:0], e_instr[14:12], e_instr[30], e_instr[19:15], e_instr[24:20], e_instr[11:7]})
                begin errors++; $display("FAIL rnd_fields cyc=%0d got=%h/%h/%b/%h/%h/%h instr=%h", n, opcode_d, funct3_d, funct7_d, rs1_d, rs2_d, rd_d, e_instr); end
`ifdef FETCH_PERF_CNT_EN
            checks++; if (perf_fetch !== m_pf || perf_bubble !== m_pb)
                begin errors++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", n, perf_fetch, perf_bubble, m_pf, m_pb); end
`endif
        end
        rst = 0; branch_taken = 0; stall_f = 0; halt = 0; step = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        m_pc = 0; m_pcd = 0; m_instr = 32'h13; m_valid = 0; m_mode = 0;
`ifdef FETCH_PERF_CNT_EN
        m_pf = 0; m_pb = 0;
`endif
        test_reset();
        test_stall();
        test_branch_over_stall();
        test_halt_step();
        test_reset_mid_step();
        test_wrap();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
